// File: rtl/apb_mgr_arbiter_pkg.sv
// apb_mgr_arbiter_pkg
//   Shared definitions for the APB manager arbiter: FSM state encoding and
//   the default per-transfer timeout length.
package apb_mgr_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_arb_state_e;

   localparam int unsigned ArbTimeoutDefault = 256;

endpackage

// File: rtl/apb_mgr_arbiter_rr_grant.sv
// rr_grant
//   Combinational rotate-priority encoder. Picks the first asserted request
//   at or after ptr, wrapping around the vector.
//   Ports:
//     req        in   N         request vector
//     ptr        in   log2(N)   highest-priority index
//     gnt_onehot out  N         one-hot grant
//     gnt_idx    out  log2(N)   index of the granted request
//     valid      out  1         at least one request present
module rr_grant #(
   parameter int unsigned N = 2
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         gnt_onehot,
   output logic [$clog2(N)-1:0] gnt_idx,
   output logic                 valid
);

   localparam int unsigned IdxW = $clog2(N);

   always_comb begin
      int unsigned          cand;
      logic [IdxW-1:0]      cand_idx;
      gnt_onehot = '0;
      gnt_idx    = '0;
      valid      = 1'b0;
      cand       = 0;
      cand_idx   = '0;
      for (int unsigned k = 0; k < N; k++) begin
         cand     = (32'(ptr) + k) % N;
         cand_idx = IdxW'(cand);
         if (!valid && req[cand_idx]) begin
            valid                = 1'b1;
            gnt_idx              = cand_idx;
            gnt_onehot[cand_idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/apb_mgr_arbiter.sv
// apb_mgr_arbiter
//   Shares one downstream APB subordinate port between NrMgr APB managers.
//   Round-robin, one transfer at a time; each granted transfer is replayed
//   downstream as a fresh SETUP/ACCESS pair. A stuck subordinate is aborted
//   after TimeoutCycles ACCESS cycles and the manager gets PSLVERR.
//   Ports:
//     clk_i, rst_ni                 clock, asynchronous active-high reset
//     mgr_psel_i/penable/pwrite     per-manager APB control
//     mgr_paddr_i/mgr_pwdata_i      per-manager address/data, manager i at slice i
//     mgr_prdata_o                  read data broadcast to all managers
//     mgr_pready_o/mgr_pslverr_o    per-manager completion and error
//     sub_*                         downstream APB subordinate port
//     busy_o                        arbiter not idle
module apb_mgr_arbiter
   import apb_mgr_arbiter_pkg::*;
#(
   parameter int unsigned NrMgr         = 2,
   parameter int unsigned AddrWidth     = 32,
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned TimeoutCycles = ArbTimeoutDefault,
   parameter int unsigned CntWidth      = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [NrMgr-1:0]           mgr_psel_i,
   input  logic [NrMgr-1:0]           mgr_penable_i,
   input  logic [NrMgr-1:0]           mgr_pwrite_i,
   input  logic [NrMgr*AddrWidth-1:0] mgr_paddr_i,
   input  logic [NrMgr*DataWidth-1:0] mgr_pwdata_i,
   output logic [DataWidth-1:0]       mgr_prdata_o,
   output logic [NrMgr-1:0]           mgr_pready_o,
   output logic [NrMgr-1:0]           mgr_pslverr_o,
   output logic                       sub_psel_o,
   output logic                       sub_penable_o,
   output logic                       sub_pwrite_o,
   output logic [AddrWidth-1:0]       sub_paddr_o,
   output logic [DataWidth-1:0]       sub_pwdata_o,
   input  logic [DataWidth-1:0]       sub_prdata_i,
   input  logic                       sub_pready_i,
   input  logic                       sub_pslverr_i,
   output logic                       busy_o
);

   localparam int unsigned IdxW = $clog2(NrMgr);
   localparam logic [CntWidth-1:0] CntLast =
      (TimeoutCycles != 0) ? CntWidth'(TimeoutCycles - 1) : '0;

   apb_arb_state_e state_q, state_d;

   logic [IdxW-1:0]      ptr_q;
   logic [IdxW-1:0]      gnt_q;
   logic [CntWidth-1:0]  cnt_q;
   logic                 write_q;
   logic [AddrWidth-1:0] addr_q;
   logic [DataWidth-1:0] wdata_q;
   logic [DataWidth-1:0] rdata_q;
   logic                 err_q;

   logic [NrMgr-1:0]     gnt_onehot;
   logic [IdxW-1:0]      gnt_idx;
   logic                 gnt_valid;
   logic                 sel_write;
   logic [AddrWidth-1:0] sel_addr;
   logic [DataWidth-1:0] sel_wdata;
   logic                 timeout;

   // Requests are taken from PSEL alone; PENABLE adds nothing the arbiter needs.
   logic penable_unused;
   assign penable_unused = &mgr_penable_i;

   rr_grant #(
      .N (NrMgr)
   ) u_rr_grant (
      .req        (mgr_psel_i),
      .ptr        (ptr_q),
      .gnt_onehot (gnt_onehot),
      .gnt_idx    (gnt_idx),
      .valid      (gnt_valid)
   );

   // AND-OR mux of the granted manager's request fields.
   always_comb begin
      sel_write = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int unsigned i = 0; i < NrMgr; i++) begin
         if (gnt_onehot[i]) begin
            sel_write = sel_write | mgr_pwrite_i[i];
            sel_addr  = sel_addr  | mgr_paddr_i[i*AddrWidth +: AddrWidth];
            sel_wdata = sel_wdata | mgr_pwdata_i[i*DataWidth +: DataWidth];
         end
      end
   end

   // Next state and outputs.
   always_comb begin
      state_d       = state_q;
      timeout       = 1'b0;
      sub_psel_o    = 1'b0;
      sub_penable_o = 1'b0;
      mgr_pready_o  = '0;
      mgr_pslverr_o = '0;
      busy_o        = (state_q != IDLE);
      unique case (state_q)
         IDLE: begin
            if (gnt_valid) state_d = SETUP;
         end
         SETUP: begin
            sub_psel_o = 1'b1;
            state_d    = ACCESS;
         end
         ACCESS: begin
            sub_psel_o    = 1'b1;
            sub_penable_o = 1'b1;
            // A PREADY on the final allowed cycle wins over the timeout.
            if (sub_pready_i) begin
               state_d = RESP;
            end else if ((TimeoutCycles != 0) && (cnt_q == CntLast)) begin
               timeout = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            for (int unsigned i = 0; i < NrMgr; i++) begin
               mgr_pready_o[i]  = (gnt_q == IdxW'(i));
               mgr_pslverr_o[i] = (gnt_q == IdxW'(i)) && err_q;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_ni) begin
      if (rst_ni) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gnt_q   <= '0;
         cnt_q   <= '0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            IDLE: begin
               if (gnt_valid) begin
                  gnt_q   <= gnt_idx;
                  write_q <= sel_write;
                  addr_q  <= sel_addr;
                  wdata_q <= sel_wdata;
               end
            end
            ACCESS: begin
               cnt_q <= cnt_q + CntWidth'(1);
               if (sub_pready_i) begin
                  rdata_q <= sub_prdata_i;
                  err_q   <= sub_pslverr_i;
               end else if (timeout) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
               end
            end
            RESP: begin
               ptr_q <= (gnt_q == IdxW'(NrMgr - 1)) ? '0 : gnt_q + IdxW'(1);
               cnt_q <= '0;
            end
            default: ;
         endcase
      end
   end

   assign sub_pwrite_o = write_q;
   assign sub_paddr_o  = addr_q;
   assign sub_pwdata_o = wdata_q;
   assign mgr_prdata_o = rdata_q;

endmodule

// File: tb/tb_apb_mgr_arbiter.sv
// tb_apb_mgr_arbiter
//   Scoreboard bench for apb_mgr_arbiter with four managers and an 8-cycle
//   timeout. Expected transfers are predicted in grant order when requests
//   are launched; a subordinate model answers from the queue head and the
//   completion monitor pops and compares.
module tb_apb_mgr_arbiter;

   localparam int unsigned NrMgr = 4;
   localparam int unsigned AW    = 32;
   localparam int unsigned DW    = 32;
   localparam int          TO    = 8;

   logic                 clk = 1'b0;
   logic                 rst_ni;
   logic [NrMgr-1:0]     psel, penable, pwrite;
   logic [NrMgr*AW-1:0]  paddr;
   logic [NrMgr*DW-1:0]  pwdata;
   logic [DW-1:0]        prdata;
   logic [NrMgr-1:0]     pready, pslverr;
   logic                 s_psel, s_penable, s_pwrite;
   logic [AW-1:0]        s_paddr;
   logic [DW-1:0]        s_pwdata, s_prdata;
   logic                 s_pready, s_pslverr;
   logic                 busy;

   logic [AW-1:0]        m_addr  [NrMgr];
   logic [DW-1:0]        m_wdata [NrMgr];

   for (genvar g = 0; g < NrMgr; g++) begin : g_pack
      assign paddr [g*AW +: AW] = m_addr[g];
      assign pwdata[g*DW +: DW] = m_wdata[g];
   end

   apb_mgr_arbiter #(
      .NrMgr         (NrMgr),
      .AddrWidth     (AW),
      .DataWidth     (DW),
      .TimeoutCycles (TO)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .mgr_psel_i    (psel),
      .mgr_penable_i (penable),
      .mgr_pwrite_i  (pwrite),
      .mgr_paddr_i   (paddr),
      .mgr_pwdata_i  (pwdata),
      .mgr_prdata_o  (prdata),
      .mgr_pready_o  (pready),
      .mgr_pslverr_o (pslverr),
      .sub_psel_o    (s_psel),
      .sub_penable_o (s_penable),
      .sub_pwrite_o  (s_pwrite),
      .sub_paddr_o   (s_paddr),
      .sub_pwdata_o  (s_pwdata),
      .sub_prdata_i  (s_prdata),
      .sub_pready_i  (s_pready),
      .sub_pslverr_i (s_pslverr),
      .busy_o        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          mgr;
      logic [AW-1:0] addr;
      logic        write;
      logic [DW-1:0] wdata;
      int          waits;
      logic [DW-1:0] sub_rdata;
      logic        sub_err;
      logic [DW-1:0] exp_rdata;
      logic        exp_err;
      int          exp_acc;
      int          exp_lat;
   } rec_t;

   rec_t        sb[$];
   rec_t        mon_r;
   int          checks   = 0;
   int          failures = 0;
   int unsigned cyc      = 0;
   int          model_ptr = 0;
   int          acc_n    = 0;
   logic [DW-1:0] last_rdata = '0;
   int          remaining [NrMgr];
   bit          done      [NrMgr];
   int unsigned issue_cyc [NrMgr];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Manager side: raise PENABLE one cycle after PSEL, and on seeing PREADY
   // either start the next queued transfer immediately or release the bus.
   initial forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NrMgr; i++) begin
         if (done[i]) begin
            done[i] = 1'b0;
            if (remaining[i] > 0) begin
               remaining[i]--;
               penable[i]   = 1'b0;
               issue_cyc[i] = cyc;
            end else begin
               psel[i]    = 1'b0;
               penable[i] = 1'b0;
            end
         end else if (psel[i]) begin
            penable[i] = 1'b1;
         end
      end
   end

   // Subordinate model and completion monitor.
   initial begin
      logic [NrMgr-1:0] exp_rdy;
      s_pready  = 1'b0;
      s_prdata  = '0;
      s_pslverr = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_ni) begin
            s_pready = 1'b0;
         end else begin
            if (s_psel && !s_penable) begin
               acc_n    = 0;
               s_pready = 1'b0;
               check_eq("busy_setup", busy, 1);
               if (sb.size() == 0) begin
                  check_eq("setup_unexpected", sb.size(), 1);
               end else begin
                  check_eq("sub_paddr", s_paddr, sb[0].addr);
                  check_eq("sub_pwrite", s_pwrite, sb[0].write);
                  if (sb[0].write) check_eq("sub_pwdata", s_pwdata, sb[0].wdata);
               end
            end else if (s_psel && s_penable) begin
               acc_n++;
               if (sb.size() != 0) begin
                  if (sb[0].write) check_eq("pwdata_stable", s_pwdata, sb[0].wdata);
                  s_pready  = (acc_n == sb[0].waits + 1);
                  s_prdata  = sb[0].sub_rdata;
                  s_pslverr = sb[0].sub_err;
               end
            end else begin
               s_pready = 1'b0;
            end
            if (pready != '0) begin
               if (sb.size() == 0) begin
                  check_eq("resp_unexpected", pready, 0);
               end else begin
                  mon_r   = sb.pop_front();
                  exp_rdy = '0;
                  exp_rdy[mon_r.mgr] = 1'b1;
                  check_eq("mgr_pready", pready, exp_rdy);
                  check_eq("mgr_pslverr", pslverr, mon_r.exp_err ? exp_rdy : '0);
                  check_eq("mgr_prdata", prdata, mon_r.exp_rdata);
                  check_eq("access_cycles", acc_n, mon_r.exp_acc);
                  if (mon_r.exp_lat != 0)
                     check_eq("latency", cyc - issue_cyc[mon_r.mgr] + 1, mon_r.exp_lat);
                  last_rdata = mon_r.exp_rdata;
               end
               for (int i = 0; i < NrMgr; i++) if (pready[i]) done[i] = 1'b1;
            end
         end
      end
   end

   task automatic start(input int i, input int n, input logic [AW-1:0] a,
                        input logic w, input logic [DW-1:0] d);
      m_addr[i]    = a;
      m_wdata[i]   = d;
      pwrite[i]    = w;
      remaining[i] = n - 1;
      psel[i]      = 1'b1;
      penable[i]   = 1'b0;
      issue_cyc[i] = cyc;
   endtask

   // Predict the grant sequence for managers launched together, each doing
   // n_each transfers, all against a subordinate with the same wait count.
   task automatic plan(input logic [NrMgr-1:0] mask, input int n_each, input int waits,
                       input logic [DW-1:0] rdata, input logic err);
      int   rem  [NrMgr];
      bit   seen [NrMgr];
      int   total;
      int   g;
      int   c;
      int   weff;
      bit   tmo;
      rec_t r;
      total = 0;
      tmo   = (waits >= TO);
      weff  = tmo ? TO - 1 : waits;
      for (int i = 0; i < NrMgr; i++) begin
         rem[i]  = mask[i] ? n_each : 0;
         seen[i] = 1'b0;
         total  += rem[i];
      end
      for (int k = 0; k < total; k++) begin
         g = -1;
         for (int j = 0; j < NrMgr; j++) begin
            c = (model_ptr + j) % NrMgr;
            if (g < 0 && rem[c] > 0) g = c;
         end
         r.mgr       = g;
         r.addr      = m_addr[g];
         r.write     = pwrite[g];
         r.wdata     = m_wdata[g];
         r.waits     = waits;
         r.sub_rdata = rdata + DW'(k);
         r.sub_err   = err;
         r.exp_rdata = tmo ? '0 : rdata + DW'(k);
         r.exp_err   = tmo ? 1'b1 : err;
         r.exp_acc   = weff + 1;
         r.exp_lat   = seen[g] ? 0 : (k + 1) * (4 + weff);
         seen[g]     = 1'b1;
         rem[g]--;
         model_ptr   = (g + 1) % NrMgr;
         sb.push_back(r);
      end
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      #2;
      check_eq("drain", sb.size(), 0);
      sb.delete();
      check_eq("busy_idle", busy, 0);
      check_eq("pready_idle", pready, 0);
      check_eq("prdata_hold", prdata, last_rdata);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_sub_psel"}, s_psel, 0);
      check_eq({tag, "_sub_penable"}, s_penable, 0);
      check_eq({tag, "_sub_pwrite"}, s_pwrite, 0);
      check_eq({tag, "_sub_paddr"}, s_paddr, 0);
      check_eq({tag, "_sub_pwdata"}, s_pwdata, 0);
      check_eq({tag, "_mgr_pready"}, pready, 0);
      check_eq({tag, "_mgr_pslverr"}, pslverr, 0);
      check_eq({tag, "_mgr_prdata"}, prdata, 0);
      check_eq({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      psel    = '0;
      penable = '0;
      pwrite  = '0;
      for (int i = 0; i < NrMgr; i++) begin
         m_addr[i]    = '0;
         m_wdata[i]   = '0;
         remaining[i] = 0;
         done[i]      = 1'b0;
         issue_cyc[i] = 0;
      end
      rst_ni = 1'b0;
      #2 rst_ni = 1'b1;
      #1 check_all_zero("reset");
      repeat (2) @(posedge clk);
      @(negedge clk) rst_ni = 1'b0;
      @(posedge clk) #2;

      // Contention from pointer 0: mgr0 then mgr1.
      start(0, 1, 32'h0000_1000, 1'b0, '0);
      start(1, 1, 32'h0000_1100, 1'b0, '0);
      plan(4'b0011, 1, 0, 32'h1111_0000, 1'b0);
      drain(100);

      // Single zero-wait read.
      start(0, 1, 32'h0000_2000, 1'b0, '0);
      plan(4'b0001, 1, 0, 32'hDEAD_BEEF, 1'b0);
      drain(100);

      // Contention repeat with pointer now at 1: mgr1 then mgr0.
      start(0, 1, 32'h0000_1200, 1'b0, '0);
      start(1, 1, 32'h0000_1300, 1'b0, '0);
      plan(4'b0011, 1, 0, 32'h2222_0000, 1'b0);
      drain(100);

      // Write with three wait states and a subordinate error.
      start(2, 1, 32'h0000_3004, 1'b1, 32'h1234_5678);
      plan(4'b0100, 1, 3, 32'hCAFE_0000, 1'b1);
      drain(100);

      // PREADY on the final allowed ACCESS cycle beats the timeout.
      start(1, 1, 32'h0000_4000, 1'b0, '0);
      plan(4'b0010, 1, TO - 1, 32'h0BAD_F00D, 1'b0);
      drain(100);

      // Subordinate never ready: aborted with PSLVERR and zero data.
      start(3, 1, 32'h0000_5000, 1'b0, '0);
      plan(4'b1000, 1, 255, 32'h7777_7777, 1'b0);
      drain(100);

      // Fairness: all four held for 12 transfers in total.
      for (int i = 0; i < NrMgr; i++)
         start(i, 3, 32'h0000_6000 + AW'(i * 16), i[0], 32'hA000_0000 + DW'(i));
      plan(4'b1111, 3, 0, 32'h3333_0000, 1'b0);
      drain(200);

      // Move the pointer to 2 before the reset test.
      start(1, 1, 32'h0000_7000, 1'b1, 32'h5555_AAAA);
      plan(4'b0010, 1, 0, 32'h4444_0000, 1'b0);
      drain(100);

      // Reset during the second wait cycle of ACCESS.
      start(3, 1, 32'h0000_8000, 1'b1, 32'h9999_0000);
      plan(4'b1000, 1, 255, 32'h8888_0000, 1'b0);
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (acc_n != 2 && n < 50);
      check_eq("reach_access2", acc_n, 2);
      rst_ni = 1'b1;
      #1 check_all_zero("midreset");
      psel    = '0;
      penable = '0;
      for (int i = 0; i < NrMgr; i++) begin
         remaining[i] = 0;
         done[i]      = 1'b0;
      end
      sb.delete();
      model_ptr  = 0;
      last_rdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_ni = 1'b0;
      @(posedge clk) #2;

      // Pointer restarts at 0 after reset: mgr0 ahead of mgr2.
      start(0, 1, 32'h0000_9000, 1'b0, '0);
      start(2, 1, 32'h0000_9200, 1'b0, '0);
      plan(4'b0101, 1, 0, 32'h6666_0000, 1'b0);
      drain(100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/apb_mgr_arbiter.md
Name: apb_mgr_arbiter

Overview:
- Shares the single peripheral APB subordinate port (the demux input feeding UART, mtimer and HETIC) between NrMgr APB managers, e.g. the core and a debug/DMA manager.
- Round-robin arbitration, one transfer at a time. Each granted transfer is re-issued as a clean SETUP/ACCESS sequence downstream.
- A per-transfer timeout returns PSLVERR to the manager if a subordinate never asserts PREADY.

Parameters:
- NrMgr, 2, number of APB managers (2..8)
- AddrWidth, 32, APB address width
- DataWidth, 32, APB data width
- TimeoutCycles, 256, ACCESS cycles before abort; 0 disables timeout
- CntWidth, $clog2(TimeoutCycles+1), timeout counter width (derived)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-high
- mgr_psel_i  in  NrMgr  per-manager PSEL
- mgr_penable_i  in  NrMgr  per-manager PENABLE
- mgr_pwrite_i  in  NrMgr  per-manager PWRITE
- mgr_paddr_i  in  NrMgr*AddrWidth  per-manager PADDR, manager i at slice i
- mgr_pwdata_i  in  NrMgr*DataWidth  per-manager PWDATA
- mgr_prdata_o  out  DataWidth  read data, broadcast, valid with mgr_pready_o
- mgr_pready_o  out  NrMgr  per-manager PREADY
- mgr_pslverr_o  out  NrMgr  per-manager PSLVERR
- sub_psel_o  out  1  downstream PSEL
- sub_penable_o  out  1  downstream PENABLE
- sub_pwrite_o  out  1  downstream PWRITE
- sub_paddr_o  out  AddrWidth  downstream PADDR
- sub_pwdata_o  out  DataWidth  downstream PWDATA
- sub_prdata_i  in  DataWidth  downstream PRDATA
- sub_pready_i  in  1  downstream PREADY
- sub_pslverr_i  in  1  downstream PSLVERR
- busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_ni=1, asynchronous):
  - state=IDLE; round-robin pointer=0; timeout counter=0.
  - All outputs 0; latched addr/data/write/rdata/err cleared.
- A request is mgr_psel_i[i]=1. Managers hold PSEL/PENABLE/addr/data stable until they see their PREADY (standard APB wait).
- IDLE: if any request is present, grant the first requester at or after the pointer (circular). Latch the granted manager's pwrite/paddr/pwdata and the grant index, then go to SETUP. Requests are sampled only in IDLE.
- SETUP: sub_psel_o=1, sub_penable_o=0, latched fields driven. Next state is ACCESS.
- ACCESS: sub_psel_o=1, sub_penable_o=1. Counter increments each cycle.
  - sub_pready_i=1: latch sub_prdata_i and sub_pslverr_i, go to RESP.
  - TimeoutCycles!=0, counter==TimeoutCycles-1 and sub_pready_i=0: latch prdata=0 and pslverr=1, go to RESP. The downstream transfer is abandoned; sub_psel_o drops.
  - PREADY arriving on the same cycle as the timeout takes precedence, so the normal response is returned.
- RESP: sub_psel_o=0.
  - mgr_pready_o[grant]=1 for exactly one cycle; mgr_prdata_o and mgr_pslverr_o[grant] come from the latches.
  - Pointer becomes (grant+1) mod NrMgr; counter cleared; next state IDLE.
- Latency: psel-to-pready is 4 cycles when the subordinate has zero wait states, plus 1 per subordinate wait cycle. IDLE always occupies one cycle between transfers, so back-to-back transfers do not overlap.
- Outputs outside RESP:
  - mgr_pready_o and mgr_pslverr_o are 0.
  - mgr_prdata_o holds its last value, except after reset, where it is 0.
- Ungranted managers see PREADY=0 and keep waiting. There is no starvation: with NrMgr requesters held high, each is served within NrMgr grants.
- Manager drops PSEL mid-transfer (protocol violation): the downstream transfer still completes and the RESP pulse is still issued. The arbiter does not recover this case.
- Reset mid-transfer: immediate return to IDLE with all sub_* low. The interrupted transfer is lost.
- Write and read are handled identically; only pwrite differs.

Decomposition:
- zeroheti_pkg gains:
  - apb_arb_state_e {IDLE, SETUP, ACCESS, RESP}, 2 bits.
  - ArbTimeoutDefault = 256.
- One sub-module, rr_grant (parameter N). Inputs: req vector and pointer. Outputs: grant one-hot, grant index, valid. Purely combinational rotate-priority-encode.
- The pointer register stays in apb_mgr_arbiter.

Test Plan:
- Single read: mgr0 reads 0x0000_2000, subordinate pready after 0 wait states with prdata 0xDEAD_BEEF -> mgr_pready_o[0] pulses on cycle 4 after psel, prdata 0xDEADBEEF, pslverr 0.
- Contention: mgr0 and mgr1 assert psel on the same cycle, pointer=0 -> mgr0 is served first (pready at cycle 4), mgr1 second (pready at cycle 8). A repeat with both held gives the order 1,0.
- Wait states plus error: write 0x1234_5678 to 0x0000_3004, subordinate inserts 3 wait cycles then pslverr=1 -> sub_pwdata_o stays stable through ACCESS, and mgr pready arrives at cycle 7 with pslverr=1.
- Timeout: TimeoutCycles=8, subordinate never readies -> sub_psel_o drops after 8 ACCESS cycles, and mgr pready+pslverr=1 arrive with prdata 0. PREADY arriving on exactly the 8th ACCESS cycle -> the normal response is returned.
- Fairness: NrMgr=4, all requesting continuously for 12 transfers -> grant order 0,1,2,3 repeated, with no grant gap larger than 4.
- Reset mid-ACCESS: assert rst_ni during the 2nd wait cycle -> all sub_* and mgr_* outputs read 0 in the same cycle, busy_o=0, and the next request is served from pointer 0.
